pipe_ctrl_sched: RTL and testbench

Pipeline control scheduler for the 5-stage RISC-V core. It takes the decoded control word from the control unit in Decode and carries it through the E, M and W stages in its own control-pipeline registers. It also detects load-use and branch hazards and drives the stall, flush and forwarding selects for the datapath. It sits between the control unit and the datapath pipeline registers, and owns every control bit past Decode.

---
 rtl/pipe_ctrl_sched_pkg.sv | 65 ++++++
 rtl/forward_unit.sv | 24 ++
 rtl/pipe_ctrl_sched.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_sched_pkg.sv
// ============================================================================
// pipe_ctrl_sched_pkg : shared control-word types, encodings and forward select
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_sched_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        RES_ALU = 1'b0,
        RES_MEM = 1'b1
    } result_src_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_control;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_e_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       result_src;
        logic [4:0] rd;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic [4:0] rd;
    } ctrl_w_t;

    localparam ctrl_e_t BUBBLE_E = '0;
    localparam ctrl_m_t BUBBLE_M = '0;
    localparam ctrl_w_t BUBBLE_W = '0;

    // The younger (M) producer wins; x0 is hardwired zero and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// forward_unit : combinational ALU operand forwarding selects for Execute
// Rev 1.0
// ============================================================================
`default_nettype none

module forward_unit (
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);
    import pipe_ctrl_sched_pkg::*;

    assign forward_a = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    assign forward_b = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_sched.sv
// ============================================================================
// pipe_ctrl_sched : E/M/W control pipeline, load-use/branch hazards, counters
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl_sched #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             ResultSrcD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             ZeroE,
    input  logic             mem_wait,
    output logic             RegWriteE,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic             MemWriteE,
    output logic             MemWriteM,
    output logic             ResultSrcE,
    output logic             ResultSrcM,
    output logic             ResultSrcW,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [2:0]       ALUControlE,
    output logic [4:0]       RdM,
    output logic [4:0]       RdW,
    output logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import pipe_ctrl_sched_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_e_t ctrl_d;
    ctrl_e_t e_q;
    ctrl_m_t m_q;
    ctrl_w_t w_q;
    logic    load_use;
    logic    branch_taken;
    logic    kill_e;

    assign ctrl_d = '{reg_write:   RegWriteD,
                      mem_write:   MemWriteD,
                      result_src:  ResultSrcD,
                      branch:      BranchD,
                      alu_src:     ALUSrcD,
                      alu_control: ALUControlD,
                      rs1:         Rs1D,
                      rs2:         Rs2D,
                      rd:          RdD};

    assign branch_taken = e_q.branch & ZeroE;
    assign load_use     = (e_q.result_src == RES_MEM) & e_q.reg_write &
                          (e_q.rd != 5'd0) & ((e_q.rd == Rs1D) | (e_q.rd == Rs2D));

    // A taken branch overrides load-use: the stalled instruction is on the wrong path.
    assign PCSrcE = branch_taken & ~mem_wait;
    assign FlushD = branch_taken & ~mem_wait;
    assign StallF = mem_wait | (load_use & ~branch_taken);
    assign StallD = StallF;
    assign kill_e = branch_taken | load_use;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q       <= BUBBLE_E;
            m_q       <= BUBBLE_M;
            w_q       <= BUBBLE_W;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_wait) begin
            e_q <= kill_e ? BUBBLE_E : ctrl_d;
            m_q <= '{reg_write:  e_q.reg_write,
                     mem_write:  e_q.mem_write,
                     result_src: e_q.result_src,
                     rd:         e_q.rd};
            w_q <= '{reg_write:  m_q.reg_write,
                     result_src: m_q.result_src,
                     rd:         m_q.rd};
            if (branch_taken) begin
                if (flush_cnt != '1)
                    flush_cnt <= flush_cnt + CNT_ONE;
            end else if (load_use) begin
                if (stall_cnt != '1)
                    stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

    assign RegWriteE   = e_q.reg_write;
    assign MemWriteE   = e_q.mem_write;
    assign ResultSrcE  = e_q.result_src;
    assign BranchE     = e_q.branch;
    assign ALUSrcE     = e_q.alu_src;
    assign ALUControlE = e_q.alu_control;
    assign RegWriteM   = m_q.reg_write;
    assign MemWriteM   = m_q.mem_write;
    assign ResultSrcM  = m_q.result_src;
    assign RdM         = m_q.rd;
    assign RegWriteW   = w_q.reg_write;
    assign ResultSrcW  = w_q.result_src;
    assign RdW         = w_q.rd;

    forward_unit u_forward_unit (
        .rs1_e       (e_q.rs1),
        .rs2_e       (e_q.rs2),
        .rd_m        (m_q.rd),
        .rd_w        (w_q.rd),
        .reg_write_m (m_q.reg_write),
        .reg_write_w (w_q.reg_write),
        .forward_a   (ForwardAE),
        .forward_b   (ForwardBE)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_sched.sv
// ============================================================================
// tb_pipe_ctrl_sched : directed vector table plus hand-written hazard sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_sched;

    localparam int CNT_W = 3;

    // control words {RegWrite, MemWrite, ResultSrc, Branch, ALUSrc, ALUControl[2:0]}
    localparam logic [7:0] C_NOP  = 8'b0000_0000;
    localparam logic [7:0] C_LW   = 8'b1010_1000;
    localparam logic [7:0] C_ADD  = 8'b1000_0000;
    localparam logic [7:0] C_SUB  = 8'b1000_0001;
    localparam logic [7:0] C_BEQ  = 8'b0001_0001;
    localparam logic [7:0] C_LDBR = 8'b1011_0000;
    localparam logic [7:0] C_ADDI = 8'b1000_1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             RegWriteD, MemWriteD, ResultSrcD, BranchD, ALUSrcD;
    logic [2:0]       ALUControlD;
    logic [4:0]       Rs1D, Rs2D, RdD;
    logic             ZeroE, mem_wait;
    logic             RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM;
    logic             ResultSrcE, ResultSrcM, ResultSrcW, BranchE, ALUSrcE;
    logic [2:0]       ALUControlE;
    logic [4:0]       RdM, RdW;
    logic             PCSrcE, StallF, StallD, FlushD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic [7:0] obs_e;
    logic [7:0] obs_m;
    logic [6:0] obs_w;
    logic [3:0] obs_haz;
    logic [3:0] obs_fwd;

    assign obs_e   = {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE};
    assign obs_m   = {RegWriteM, MemWriteM, ResultSrcM, RdM};
    assign obs_w   = {RegWriteW, ResultSrcW, RdW};
    assign obs_haz = {PCSrcE, StallF, StallD, FlushD};
    assign obs_fwd = {ForwardAE, ForwardBE};

    always #5 clk = ~clk;

    pipe_ctrl_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE), .mem_wait(mem_wait),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [7:0] d_ctl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       zero;
        logic [7:0] e_ctl;
        logic [7:0] m;
        logic [6:0] w;
        logic [3:0] haz;
        logic [3:0] fwd;
        logic [2:0] scnt;
        logic [2:0] fcnt;
    } vec_t;

    vec_t vecs [19];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [7:0] e, input logic [7:0] m,
                             input logic [6:0] w, input logic [3:0] haz, input logic [3:0] fwd,
                             input logic [2:0] sc, input logic [2:0] fc);
        chk({tag, ".ctl"}, 32'({obs_e, obs_m, obs_w}), 32'({e, m, w}));
        chk({tag, ".haz"}, 32'(obs_haz), 32'(haz));
        chk({tag, ".fwd"}, 32'(obs_fwd), 32'(fwd));
        chk({tag, ".cnt"}, 32'({stall_cnt, flush_cnt}), 32'({sc, fc}));
    endtask

    task automatic set_d(input logic [7:0] c, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
        {RegWriteD, MemWriteD, ResultSrcD, BranchD, ALUSrcD, ALUControlD} = c;
        Rs1D = a;
        Rs2D = b;
        RdD  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        //           D word                      zero  E      M             W            haz      fwd      sc    fc
        vecs[0]  = '{C_LW,   5'd1, 5'd0, 5'd5, 1'b0, C_NOP, 8'b00000000, 7'b0000000, 4'b0000, 4'b0000, 3'd0, 3'd0};
        vecs[1]  = '{C_ADD,  5'd5, 5'd1, 5'd6, 1'b0, C_LW,  8'b00000000, 7'b0000000, 4'b0110, 4'b0000, 3'd0, 3'd0};
        vecs[2]  = '{C_ADD,  5'd5, 5'd1, 5'd6, 1'b0, C_NOP, 8'b10100101, 7'b0000000, 4'b0000, 4'b0000, 3'd1, 3'd0};
        vecs[3]  = '{C_ADD,  5'd1, 5'd2, 5'd3, 1'b0, C_ADD, 8'b00000000, 7'b1100101, 4'b0000, 4'b0100, 3'd1, 3'd0};
        vecs[4]  = '{C_ADD,  5'd1, 5'd2, 5'd3, 1'b0, C_ADD, 8'b10000110, 7'b0000000, 4'b0000, 4'b0000, 3'd1, 3'd0};
        vecs[5]  = '{C_SUB,  5'd3, 5'd3, 5'd4, 1'b0, C_ADD, 8'b10000011, 7'b1000110, 4'b0000, 4'b0000, 3'd1, 3'd0};
        vecs[6]  = '{C_NOP,  5'd0, 5'd0, 5'd0, 1'b0, C_SUB, 8'b10000011, 7'b1000011, 4'b0000, 4'b1010, 3'd1, 3'd0};
        vecs[7]  = '{C_BEQ,  5'd1, 5'd2, 5'd0, 1'b0, C_NOP, 8'b10000100, 7'b1000011, 4'b0000, 4'b0000, 3'd1, 3'd0};
        vecs[8]  = '{C_ADD,  5'd5, 5'd1, 5'd6, 1'b0, C_BEQ, 8'b00000000, 7'b1000100, 4'b0000, 4'b0000, 3'd1, 3'd0};
        vecs[9]  = '{C_BEQ,  5'd1, 5'd2, 5'd0, 1'b0, C_ADD, 8'b00000000, 7'b0000000, 4'b0000, 4'b0000, 3'd1, 3'd0};
        vecs[10] = '{C_ADD,  5'd1, 5'd2, 5'd3, 1'b1, C_BEQ, 8'b10000110, 7'b0000000, 4'b1001, 4'b0000, 3'd1, 3'd0};
        vecs[11] = '{C_LDBR, 5'd1, 5'd2, 5'd5, 1'b0, C_NOP, 8'b00000000, 7'b1000110, 4'b0000, 4'b0000, 3'd1, 3'd1};
        vecs[12] = '{C_ADD,  5'd5, 5'd1, 5'd6, 1'b1, C_LDBR,8'b00000000, 7'b0000000, 4'b1001, 4'b0000, 3'd1, 3'd1};
        vecs[13] = '{C_NOP,  5'd0, 5'd0, 5'd0, 1'b0, C_NOP, 8'b10100101, 7'b0000000, 4'b0000, 4'b0000, 3'd1, 3'd2};
        vecs[14] = '{C_ADDI, 5'd7, 5'd0, 5'd0, 1'b0, C_NOP, 8'b00000000, 7'b1100101, 4'b0000, 4'b0000, 3'd1, 3'd2};
        vecs[15] = '{C_ADDI, 5'd7, 5'd0, 5'd0, 1'b0, C_ADDI,8'b00000000, 7'b0000000, 4'b0000, 4'b0000, 3'd1, 3'd2};
        vecs[16] = '{C_ADD,  5'd0, 5'd0, 5'd9, 1'b0, C_ADDI,8'b10000000, 7'b0000000, 4'b0000, 4'b0000, 3'd1, 3'd2};
        vecs[17] = '{C_LW,   5'd1, 5'd0, 5'd0, 1'b0, C_ADD, 8'b10000000, 7'b1000000, 4'b0000, 4'b0000, 3'd1, 3'd2};
        vecs[18] = '{C_ADD,  5'd0, 5'd0, 5'd6, 1'b0, C_LW,  8'b10001001, 7'b1000000, 4'b0000, 4'b0000, 3'd1, 3'd2};

        rst      = 1'b0;
        ZeroE    = 1'b0;
        mem_wait = 1'b0;
        set_d(C_NOP, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            set_d(vecs[i].d_ctl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
            ZeroE = vecs[i].zero;
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].e_ctl, vecs[i].m, vecs[i].w,
                      vecs[i].haz, vecs[i].fwd, vecs[i].scnt, vecs[i].fcnt);
            step();
        end
        ZeroE = 1'b0;

        // load-use hazard frozen by mem_wait for three cycles
        set_d(C_LW, 5'd1, 5'd0, 5'd5);
        @(negedge clk);
        check_all("lw_x5", C_ADD, 8'b10100000, 7'b1001001, '0, '0, 3'd1, 3'd2);
        step();
        set_d(C_ADD, 5'd5, 5'd1, 5'd6);
        mem_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_all($sformatf("frz%0d", k), C_LW, 8'b10000110, 7'b1100000, 4'b0110, '0, 3'd1, 3'd2);
            step();
        end
        mem_wait = 1'b0;
        @(negedge clk);
        check_all("frz_rel", C_LW, 8'b10000110, 7'b1100000, 4'b0110, '0, 3'd1, 3'd2);
        step();
        @(negedge clk);
        check_all("frz_bub", C_NOP, 8'b10100101, 7'b1000110, '0, '0, 3'd2, 3'd2);
        step();
        set_d(C_BEQ, 5'd1, 5'd2, 5'd0);
        @(negedge clk);
        check_all("fwd_w", C_ADD, 8'b00000000, 7'b1100101, '0, 4'b0100, 3'd2, 3'd2);
        step();

        // taken branch masked while frozen
        set_d(C_NOP, 5'd0, 5'd0, 5'd0);
        ZeroE    = 1'b1;
        mem_wait = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_all($sformatf("br_frz%0d", k), C_BEQ, 8'b10000110, 7'b0000000, 4'b0110, '0, 3'd2, 3'd2);
            step();
        end
        mem_wait = 1'b0;
        @(negedge clk);
        check_all("br_rel", C_BEQ, 8'b10000110, 7'b0000000, 4'b1001, '0, 3'd2, 3'd2);
        step();
        ZeroE = 1'b0;
        @(negedge clk);
        check_all("br_done", C_NOP, 8'b00000000, 7'b1000110, '0, '0, 3'd2, 3'd3);

        // flush counter saturation
        for (int i = 0; i < 6; i++) begin
            set_d(C_BEQ, 5'd1, 5'd2, 5'd0);
            ZeroE = 1'b0;
            step();
            set_d(C_NOP, 5'd0, 5'd0, 5'd0);
            ZeroE = 1'b1;
            step();
            ZeroE = 1'b0;
            @(negedge clk);
            chk($sformatf("fsat%0d", i), 32'(flush_cnt), 32'((4 + i > 7) ? 7 : 4 + i));
        end
        chk("fsat_scnt", 32'(stall_cnt), 32'd2);

        // stall counter saturation
        for (int i = 0; i < 6; i++) begin
            set_d(C_LW, 5'd1, 5'd0, 5'd5);
            step();
            set_d(C_ADD, 5'd5, 5'd1, 5'd6);
            step();
            step();
            @(negedge clk);
            chk($sformatf("ssat%0d", i), 32'(stall_cnt), 32'((3 + i > 7) ? 7 : 3 + i));
        end

        // asynchronous reset in the middle of a load-use stall
        set_d(C_LW, 5'd1, 5'd0, 5'd5);
        step();
        set_d(C_ADD, 5'd5, 5'd1, 5'd6);
        @(negedge clk);
        chk("pre_rst_stall", 32'({StallF, StallD}), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_all("rst_async", '0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_no_stale", 32'(obs_haz), 32'd0);
        step();
        check_all("rst_first", C_ADD, '0, '0, '0, '0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
